// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - CPU write-path bundle for the UART transmit FIFO
interface uart_tx_fifo_if #(
    parameter int FIFO_ADDR_WIDTH = 2
) ();
    logic                       write_enable;
    logic [7:0]                 write_data;
    logic                       full;
    logic [FIFO_ADDR_WIDTH:0]   count;
    logic                       overflow;

    modport master (
        output write_enable,
        output write_data,
        input  full,
        input  count,
        input  overflow
    );

    modport slave (
        input  write_enable,
        input  write_data,
        output full,
        output count,
        output overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART serialiser on a fixed clock divider
module uart_tx_fifo #(
    parameter int CLOCKS_PER_BIT  = 69,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic               clock_input,
    input  logic               reset,
    uart_tx_fifo_if.slave      wr,
    output logic               busy,
    output logic               tx
);
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [15:0] BAUD_LAST = 16'(CLOCKS_PER_BIT - 1);
    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_WIDTH:0] CNT_ONE = (FIFO_ADDR_WIDTH + 1)'(1);
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE = FIFO_ADDR_WIDTH'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [15:0]                baud_q, baud_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic [7:0]                 mem_q [DEPTH];

    logic full_w;
    logic push;
    logic pop;
    logic baud_end;
    logic has_data;

    assign full_w   = (count_q == DEPTH_CNT);
    assign push     = wr.write_enable && !full_w;
    assign baud_end = (baud_q == BAUD_LAST);
    assign has_data = (count_q != '0);

    assign wr.full     = full_w;
    assign wr.count    = count_q;
    assign wr.overflow = overflow_q;
    assign busy        = (state_q != S_IDLE) || has_data;
    assign tx          = tx_q;

    // tx_d is always the line level for the cycle after this edge, so tx comes straight off a flop
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_end ? 16'd0 : baud_q + 16'd1;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                tx_d   = 1'b1;
                if (has_data) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (has_data) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr.write_enable && full_w;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        // the shift register is loaded only here, so later pushes never touch the byte on the line
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_input) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock_input) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= wr.write_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo at two baud divisors
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int D     = 4;
    localparam int CPB_B = 69;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic busy_a, tx_a, busy_b, tx_b;

    uart_tx_fifo_if ifa ();
    uart_tx_fifo_if ifb ();

    uart_tx_fifo #(.CLOCKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(2)) dut_a (
        .clock_input (clk),
        .reset       (rst_a),
        .wr          (ifa),
        .busy        (busy_a),
        .tx          (tx_a)
    );

    uart_tx_fifo #(.FIFO_ADDR_WIDTH(2)) dut_b (
        .clock_input (clk),
        .reset       (rst_b),
        .wr          (ifb),
        .busy        (busy_b),
        .tx          (tx_b)
    );

    int total = 0;
    int bad   = 0;

    byte unsigned sb_q[$];
    byte unsigned mq[$];
    bit           in_frame = 1'b0;
    byte unsigned frame_byte = 8'd0;
    int           frame_t = 0;
    bit           m_ovf = 1'b0;
    bit           b_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected line level from the frame position: start, 8 data bits LSB first, stop
    function automatic int exp_tx();
        int k;
        if (!in_frame) return 1;
        k = frame_t / CPB;
        if (k == 0) return 0;
        if (k == 9) return 1;
        return int'(frame_byte[k-1]);
    endfunction

    // Reference model: queue of waiting bytes plus one frame occupying the line for FRAME cycles
    initial begin
        int n;
        bit do_pop;
        forever begin
            @(posedge clk);
            if (rst_a) begin
                mq.delete();
                sb_q.delete();
                in_frame = 1'b0;
                m_ovf    = 1'b0;
            end else begin
                n      = mq.size();
                do_pop = (n > 0) && (!in_frame || frame_t == FRAME - 1);
                m_ovf  = ifa.write_enable && (n == D);
                if (ifa.write_enable && n < D) begin
                    mq.push_back(ifa.write_data);
                    sb_q.push_back(ifa.write_data);
                end
                if (do_pop) begin
                    frame_byte = mq.pop_front();
                    in_frame   = 1'b1;
                    frame_t    = 0;
                end else if (in_frame) begin
                    if (frame_t == FRAME - 1) in_frame = 1'b0;
                    else frame_t++;
                end
            end
            #1;
            chk("tx", int'(tx_a), exp_tx());
            chk("count", int'(ifa.count), mq.size());
            chk("full", int'(ifa.full), int'(mq.size() == D));
            chk("overflow", int'(ifa.overflow), int'(m_ovf));
            chk("busy", int'(busy_a), int'(in_frame || mq.size() > 0));
        end
    end

    // Receiver: decodes frames off tx_a and pops the scoreboard
    initial begin
        bit active = 1'b0;
        int t = 0;
        byte unsigned got = 8'd0;
        byte unsigned want;
        forever begin
            @(posedge clk);
            #2;
            if (rst_a) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx_a == 1'b0) begin
                    active = 1'b1;
                    t      = 0;
                end
            end else begin
                t++;
                if (t == CPB / 2) chk("rx_start_bit", int'(tx_a), 0);
                if (t >= CPB && t < 9 * CPB && (t % CPB) == CPB / 2)
                    got[t / CPB - 1] = tx_a;
                if (t == 9 * CPB + CPB / 2) begin
                    chk("rx_stop_bit", int'(tx_a), 1);
                    if (sb_q.size() == 0) begin
                        chk("rx_unexpected_frame", int'(got), -1);
                    end else begin
                        want = sb_q.pop_front();
                        chk("rx_byte", int'(got), int'(want));
                    end
                end
                if (t == FRAME - 1) active = 1'b0;
            end
        end
    end

    task automatic push_a(input byte unsigned d);
        ifa.write_enable = 1'b1;
        ifa.write_data   = d;
        @(negedge clk);
        ifa.write_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Divider-69 instance: latency, start-bit length, frame length and decoded byte
    initial begin
        logic tx_s [700];
        logic busy_s [700];
        int lat;
        int run;
        int first_idle;
        byte unsigned dec;
        rst_b = 1'b1;
        ifb.write_enable = 1'b0;
        ifb.write_data   = 8'h00;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        ifb.write_enable = 1'b1;
        ifb.write_data   = 8'h41;
        @(posedge clk);
        @(negedge clk);
        ifb.write_enable = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #2;
            if (tx_b == 1'b0) begin
                lat = i;
                break;
            end
        end
        chk("b_latency", lat, 1);
        if (lat > 0) begin
            tx_s[0]   = tx_b;
            busy_s[0] = busy_b;
            for (int t = 1; t < 700; t++) begin
                @(posedge clk);
                #2;
                tx_s[t]   = tx_b;
                busy_s[t] = busy_b;
            end
            run = 0;
            while (run < 700 && tx_s[run] == 1'b0) run++;
            chk("b_start_len", run, CPB_B);
            for (int k = 0; k < 8; k++) dec[k] = tx_s[(k + 1) * CPB_B + CPB_B / 2];
            chk("b_byte", int'(dec), 8'h41);
            chk("b_stop_bit", int'(tx_s[9 * CPB_B + CPB_B / 2]), 1);
            first_idle = -1;
            for (int t = 0; t < 700; t++) begin
                if (busy_s[t] == 1'b0) begin
                    first_idle = t;
                    break;
                end
            end
            chk("b_frame_len", first_idle, 10 * CPB_B);
        end
        b_done = 1'b1;
    end

    initial begin
        rst_a = 1'b1;
        ifa.write_enable = 1'b0;
        ifa.write_data   = 8'h00;
        idle(3);
        rst_a = 1'b0;

        push_a(8'hA5);
        idle(50);

        push_a(8'h00);
        push_a(8'hFF);
        push_a(8'h55);
        push_a(8'h0F);
        idle(4 * FRAME + 10);

        // fill an empty FIFO behind a frame in flight, fifth push overflows
        push_a(8'h11);
        idle(3);
        for (int i = 0; i < 5; i++) push_a(8'($urandom));
        idle(5 * FRAME + 10);

        // reset during data bit 3 of 0x3C with two bytes waiting
        push_a(8'h3C);
        push_a(8'h12);
        push_a(8'h34);
        idle(16);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        idle(30);
        push_a(8'h81);
        idle(FRAME + 10);

        // hold write_enable while full so a push lands on every pop edge
        for (int i = 0; i < 5; i++) push_a(8'($urandom));
        for (int i = 0; i < 90; i++) begin
            ifa.write_enable = 1'b1;
            ifa.write_data   = 8'($urandom);
            @(negedge clk);
        end
        ifa.write_enable = 1'b0;
        idle(6 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            ifa.write_enable = ($urandom_range(3) == 0);
            ifa.write_data   = 8'($urandom);
            rst_a            = ($urandom_range(299) == 0);
            @(negedge clk);
        end
        ifa.write_enable = 1'b0;
        rst_a            = 1'b0;
        idle(6 * FRAME);

        for (int i = 0; i < 2000 && !b_done; i++) @(negedge clk);
        chk("b_done", int'(b_done), 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
